sha_nonce_scheduler: RTL

- Sequences a fixed pool of NUM_UNITS SHA-256 phase-2/3 units across a nonce range that may exceed the pool size.
- Issues batches of consecutive nonces, waits for all units to finish, and captures each unit's H0 result.
- Streams captured results to memory through the shared write port, then launches the next batch.
- Sits between the top-level bitcoin hashing FSM, which supplies the precomputed block-1 hash and starts it, and the replicated sha256_unit instances.

---
 rtl/sha_nonce_scheduler_pkg.sv | 34 +++
 rtl/sha_result_buffer.sv | 33 +++
 rtl/sha_nonce_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sha_nonce_scheduler_pkg.sv
`default_nettype none
// sha_pkg -- shared scheduler state type, word type and SHA-256 round constants.  Rev 1.0
package sha_pkg;

    typedef logic [31:0] WORD;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_WRITE  = 2'd3
    } sched_state_t;

    localparam WORD K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage
`default_nettype wire

// File: rtl/sha_result_buffer.sv
`default_nettype none
// sha_result_buffer -- NUM_UNITS x 32 register file, parallel load, indexed read.  Rev 1.0
module sha_result_buffer
    import sha_pkg::*;
#(
    parameter int NUM_UNITS = 16
)(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          load,
    input  logic [32*NUM_UNITS-1:0]       load_data,
    input  logic [$clog2(NUM_UNITS)-1:0]  rd_idx,
    output logic [31:0]                   rd_data
);

    WORD entries [NUM_UNITS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                entries[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                entries[i] <= load_data[32*i +: 32];
            end
        end
    end

    assign rd_data = entries[rd_idx];

endmodule
`default_nettype wire

// File: rtl/sha_nonce_scheduler.sv
`default_nettype none
// sha_nonce_scheduler -- walks a nonce range in NUM_UNITS-wide batches over a SHA unit pool
// and streams each batch's H0 results to memory.  Rev 1.0
module sha_nonce_scheduler
    import sha_pkg::*;
#(
    parameter int NUM_UNITS = 16,
    parameter int TIMEOUT   = 1024
)(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [31:0]               nonce_base,
    input  logic [15:0]               nonce_count,
    input  logic [15:0]               output_addr,
    output logic                      done,
    output logic                      error,
    output logic                      unit_start,
    output logic [31:0]               unit_nonce,
    input  logic [NUM_UNITS-1:0]      unit_done,
    input  logic [32*NUM_UNITS-1:0]   unit_result,
    output logic                      mem_we,
    output logic [15:0]               mem_addr,
    output logic [31:0]               mem_write_data
);

    localparam int              IDX_W      = $clog2(NUM_UNITS);
    localparam int              WD_W       = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W:0]  FULL_BATCH = (IDX_W+1)'(NUM_UNITS);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam WORD             NONCE_STEP = WORD'(NUM_UNITS);

    sched_state_t     state;
    WORD              cur_nonce;
    logic [15:0]      remaining;
    logic [15:0]      wr_addr;
    logic [IDX_W:0]   batch_len;
    logic [IDX_W-1:0] wr_idx;
    logic [WD_W-1:0]  wdog;

    logic             capture;
    logic             last_write;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_data;
    logic [15:0]      remaining_next;

    // wdog==0 marks the first WAIT cycle, where unit_done still reflects the previous batch
    assign capture        = (state == S_WAIT) && (wdog != '0) && (&unit_done);
    assign last_write     = ({1'b0, wr_idx} == (batch_len - 1'b1));
    assign rd_idx         = wr_idx + 1'b1;
    assign remaining_next = remaining - 16'(batch_len);
    assign done           = (state == S_IDLE);

    sha_result_buffer #(
        .NUM_UNITS (NUM_UNITS)
    ) u_result_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (capture),
        .load_data (unit_result),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            cur_nonce      <= '0;
            remaining      <= '0;
            wr_addr        <= '0;
            batch_len      <= '0;
            wr_idx         <= '0;
            wdog           <= '0;
            error          <= 1'b0;
            unit_start     <= 1'b0;
            unit_nonce     <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
        end else begin
            unit_start <= 1'b0;
            mem_we     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && (nonce_count != '0)) begin
                        cur_nonce  <= nonce_base;
                        remaining  <= nonce_count;
                        wr_addr    <= output_addr;
                        error      <= 1'b0;
                        wr_idx     <= '0;
                        wdog       <= '0;
                        unit_start <= 1'b1;
                        unit_nonce <= nonce_base;
                        state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    batch_len <= (remaining < 16'(NUM_UNITS)) ? remaining[IDX_W:0] : FULL_BATCH;
                    wdog      <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (capture) begin
                        // word 0 goes straight from the units; the buffer feeds the rest
                        wr_idx         <= '0;
                        mem_we         <= 1'b1;
                        mem_addr       <= wr_addr;
                        mem_write_data <= unit_result[31:0];
                        wr_addr        <= wr_addr + 16'd1;
                        state          <= S_WRITE;
                    end else if (wdog == WD_LAST) begin
                        error <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (last_write) begin
                        cur_nonce <= cur_nonce + NONCE_STEP;
                        remaining <= remaining_next;
                        if (remaining_next == '0) begin
                            state <= S_IDLE;
                        end else begin
                            unit_start <= 1'b1;
                            unit_nonce <= cur_nonce + NONCE_STEP;
                            state      <= S_LAUNCH;
                        end
                    end else begin
                        wr_idx         <= rd_idx;
                        mem_we         <= 1'b1;
                        mem_addr       <= wr_addr;
                        mem_write_data <= rd_data;
                        wr_addr        <= wr_addr + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
